// File: rtl/corr_candidate_loader_pkg.sv
// Shared definitions for the candidate loader and the 16-way correlator.
package corr_candidate_loader_pkg;

    localparam int WIDTH    = 32;
    localparam int NUM_CAND = 16;
    localparam int IDX_W    = 4;
    localparam int CNT_W    = 5;

    // Word count at which the incoming word is the target rather than a candidate
    localparam logic [CNT_W-1:0] TARGET_COUNT = 5'd16;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

endpackage

// File: rtl/corr_candidate_loader.sv
// Serial loader that fills the correlator's candidate bank and target,
// waits for the registered best-match index and holds it until acknowledged.
// SETTLE must be at least 2 because the correlator registers its output.
module corr_candidate_loader
    import corr_candidate_loader_pkg::*;
#(
    parameter int SETTLE = 2
)
(
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Clear,
    input  logic [WIDTH-1:0]          In_Data,
    input  logic                      In_Valid,
    output logic                      In_Ready,
    output logic [NUM_CAND*WIDTH-1:0] Cand_Flat,
    output logic [WIDTH-1:0]          Target_Num,
    output logic                      Bank_Valid,
    input  logic [IDX_W-1:0]          Corr_Index,
    output logic [IDX_W-1:0]          Result_Index,
    output logic                      Result_Valid,
    input  logic                      Result_Ack
);

    localparam int SET_W = $clog2(SETTLE) + 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [SET_W-1:0]            settle_cnt_q, settle_cnt_d;
    logic [NUM_CAND*WIDTH-1:0]   cand_q, cand_d;
    logic [WIDTH-1:0]            target_q, target_d;
    logic                        bank_valid_q, bank_valid_d;
    logic [IDX_W-1:0]            result_index_q, result_index_d;
    logic                        result_valid_q, result_valid_d;
    logic                        in_ready;
    logic                        accept;
    logic [NUM_CAND-1:0]         slot_we;

    // Next-state, counters, decoded slot writes and result capture
    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        settle_cnt_d   = settle_cnt_q;
        cand_d         = cand_q;
        target_d       = target_q;
        bank_valid_d   = bank_valid_q;
        result_index_d = result_index_q;
        result_valid_d = result_valid_q;
        in_ready       = (state_q == ST_LOAD);
        accept         = in_ready && In_Valid && !Clear;
        slot_we        = '0;

        for (int k = 0; k < NUM_CAND; k++) begin
            slot_we[k] = accept && (count_q == CNT_W'(k));
            if (slot_we[k]) begin
                cand_d[WIDTH*k +: WIDTH] = In_Data;
            end
        end

        if (Clear) begin
            state_d        = ST_LOAD;
            count_d        = '0;
            settle_cnt_d   = '0;
            bank_valid_d   = 1'b0;
            result_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (accept) begin
                        if (count_q == TARGET_COUNT) begin
                            target_d     = In_Data;
                            bank_valid_d = 1'b1;
                            settle_cnt_d = '0;
                            state_d      = ST_SETTLE;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        result_index_d = Corr_Index;
                        result_valid_d = 1'b1;
                        state_d        = ST_HOLD;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (Result_Ack) begin
                        state_d        = ST_LOAD;
                        count_d        = '0;
                        bank_valid_d   = 1'b0;
                        result_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_LOAD;
                    count_d = '0;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q        <= ST_LOAD;
            count_q        <= '0;
            settle_cnt_q   <= '0;
            cand_q         <= '0;
            target_q       <= '0;
            bank_valid_q   <= 1'b0;
            result_index_q <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            settle_cnt_q   <= settle_cnt_d;
            cand_q         <= cand_d;
            target_q       <= target_d;
            bank_valid_q   <= bank_valid_d;
            result_index_q <= result_index_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign In_Ready     = in_ready;
    assign Cand_Flat    = cand_q;
    assign Target_Num   = target_q;
    assign Bank_Valid   = bank_valid_q;
    assign Result_Index = result_index_q;
    assign Result_Valid = result_valid_q;

endmodule

// File: tb/tb_corr_candidate_loader.sv
// Directed bench for corr_candidate_loader with a behavioural registered correlator.
module tb_corr_candidate_loader;
    import corr_candidate_loader_pkg::*;

    localparam int CW = 512;

    logic                      Clock = 1'b0;
    logic                      Reset;
    logic                      Clear;
    logic [WIDTH-1:0]          In_Data;
    logic                      In_Valid;
    logic                      In_Ready;
    logic [NUM_CAND*WIDTH-1:0] Cand_Flat;
    logic [WIDTH-1:0]          Target_Num;
    logic                      Bank_Valid;
    logic [IDX_W-1:0]          Corr_Index;
    logic [IDX_W-1:0]          Result_Index;
    logic                      Result_Valid;
    logic                      Result_Ack;

    int tests_run    = 0;
    int tests_failed = 0;
    int accepted_words = 0;

    logic [NUM_CAND*WIDTH-1:0] model_cand;
    logic [WIDTH-1:0]          model_target;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] target;
        logic [WIDTH-1:0] fill;
        int               match_slot;
        bit               gaps;
        bit               junk;
        bit               ack_in_load;
        logic [IDX_W-1:0] exp_index;
    } vec_t;

    vec_t vecs[4];

    corr_candidate_loader #(.SETTLE(2)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Clear        (Clear),
        .In_Data      (In_Data),
        .In_Valid     (In_Valid),
        .In_Ready     (In_Ready),
        .Cand_Flat    (Cand_Flat),
        .Target_Num   (Target_Num),
        .Bank_Valid   (Bank_Valid),
        .Corr_Index   (Corr_Index),
        .Result_Index (Result_Index),
        .Result_Valid (Result_Valid),
        .Result_Ack   (Result_Ack)
    );

    // Free-running clock, 10 ns period
    always #5 Clock = ~Clock;

    // Smallest Hamming distance to the target wins; lowest index on ties
    function automatic logic [IDX_W-1:0] bestIndex(input logic [NUM_CAND*WIDTH-1:0] c,
                                                   input logic [WIDTH-1:0] t);
        logic [IDX_W-1:0] best;
        int               best_d;
        int               d;
        best   = '0;
        best_d = WIDTH + 1;
        for (int k = 0; k < NUM_CAND; k++) begin
            d = $countones(c[WIDTH*k +: WIDTH] ^ t);
            if (d < best_d) begin
                best_d = d;
                best   = IDX_W'(k);
            end
        end
        return best;
    endfunction

    // Registered correlator stand-in
    always @(posedge Clock or posedge Reset) begin
        if (Reset) Corr_Index <= '0;
        else       Corr_Index <= bestIndex(Cand_Flat, Target_Num);
    end

    // Count handshakes the loader actually takes
    always @(posedge Clock) begin
        if (!Reset && In_Valid && In_Ready && !Clear) accepted_words <= accepted_words + 1;
    end

    task automatic checkOutput(input string name, input logic [CW-1:0] actual,
                               input logic [CW-1:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic sendWord(input logic [WIDTH-1:0] data, input bit gaps, input bit ack);
        In_Valid   = 1'b1;
        In_Data    = data;
        Result_Ack = ack;
        tick();
        In_Valid   = 1'b0;
        Result_Ack = 1'b0;
        if (gaps) begin
            In_Data = ~data;
            tick();
        end
    endtask

    // Loads 16 candidates and the target; returns one step after the target edge
    task automatic applyStimulus(input vec_t v);
        logic [WIDTH-1:0] w;
        accepted_words = 0;
        for (int k = 0; k < NUM_CAND; k++) begin
            w = (k == v.match_slot) ? v.target : v.fill;
            sendWord(w, v.gaps, v.ack_in_load && (k == 5));
            model_cand[WIDTH*k +: WIDTH] = w;
        end
        checkOutput({v.name, " valid_before_target"}, CW'(Result_Valid), CW'(1'b0));
        checkOutput({v.name, " bank_before_target"}, CW'(Bank_Valid), CW'(1'b0));
        In_Valid = 1'b1;
        In_Data  = v.target;
        tick();
        model_target = v.target;
        if (v.junk) In_Data = 32'hBAD0_BAD0;
        else        In_Valid = 1'b0;
    endtask

    // Checks settle latency, hold stability and the ack (or clear) exit
    task automatic runResult(input vec_t v, input bit exit_by_clear);
        int hold_cycles;
        checkOutput({v.name, " settle_bank_valid"}, CW'(Bank_Valid), CW'(1'b1));
        checkOutput({v.name, " settle_in_ready"}, CW'(In_Ready), CW'(1'b0));
        checkOutput({v.name, " target"}, CW'(Target_Num), CW'(model_target));
        tick();
        checkOutput({v.name, " valid_e0p1"}, CW'(Result_Valid), CW'(1'b0));
        tick();
        checkOutput({v.name, " valid_e0p2"}, CW'(Result_Valid), CW'(1'b1));
        checkOutput({v.name, " index"}, CW'(Result_Index), CW'(v.exp_index));
        checkOutput({v.name, " cand_flat"}, CW'(Cand_Flat), CW'(model_cand));
        hold_cycles = v.junk ? 10 : 2;
        for (int i = 0; i < hold_cycles; i++) tick();
        checkOutput({v.name, " hold_valid"}, CW'(Result_Valid), CW'(1'b1));
        checkOutput({v.name, " hold_index"}, CW'(Result_Index), CW'(v.exp_index));
        checkOutput({v.name, " hold_cand"}, CW'(Cand_Flat), CW'(model_cand));
        checkOutput({v.name, " hold_target"}, CW'(Target_Num), CW'(model_target));
        checkOutput({v.name, " words_accepted"}, CW'(accepted_words), CW'(17));
        In_Valid = 1'b0;
        Result_Ack = 1'b1;
        if (exit_by_clear) Clear = 1'b1;
        tick();
        Result_Ack = 1'b0;
        Clear      = 1'b0;
        checkOutput({v.name, " exit_valid"}, CW'(Result_Valid), CW'(1'b0));
        checkOutput({v.name, " exit_bank"}, CW'(Bank_Valid), CW'(1'b0));
        checkOutput({v.name, " exit_ready"}, CW'(In_Ready), CW'(1'b1));
        checkOutput({v.name, " exit_index_kept"}, CW'(Result_Index), CW'(v.exp_index));
    endtask

    initial begin
        vec_t v;

        vecs[0] = '{"slot4", 32'hA5A5_A5A5, 32'h0000_0000, 4, 1'b0, 1'b0, 1'b0, 4'd4};
        vecs[1] = '{"slot4_gaps", 32'hA5A5_A5A5, 32'h0000_0000, 4, 1'b1, 1'b1, 1'b0, 4'd4};
        vecs[2] = '{"slot15", 32'h1234_5678, 32'hEDCB_A987, 15, 1'b0, 1'b0, 1'b0, 4'd15};
        vecs[3] = '{"slot9", 32'hDEAD_BEEF, 32'hFFFF_0000, 9, 1'b0, 1'b0, 1'b0, 4'd9};

        Reset      = 1'b1;
        Clear      = 1'b0;
        In_Data    = '0;
        In_Valid   = 1'b0;
        Result_Ack = 1'b0;
        model_cand   = '0;
        model_target = '0;

        #12;
        checkOutput("reset cand_flat", CW'(Cand_Flat), CW'(0));
        checkOutput("reset target", CW'(Target_Num), CW'(0));
        checkOutput("reset bank_valid", CW'(Bank_Valid), CW'(1'b0));
        checkOutput("reset result_valid", CW'(Result_Valid), CW'(1'b0));
        checkOutput("reset result_index", CW'(Result_Index), CW'(0));
        @(negedge Clock);
        Reset = 1'b0;
        tick();
        checkOutput("post_reset in_ready", CW'(In_Ready), CW'(1'b1));

        for (int i = 0; i < 4; i++) begin
            $display("[TB] vector %s", vecs[i].name);
            applyStimulus(vecs[i]);
            runResult(vecs[i], 1'b0);
        end

        // Clear during a partial load, then a fresh bank, then clear out of HOLD
        $display("[TB] clear mid-load");
        for (int k = 0; k < 7; k++) begin
            sendWord(32'h7777_0000 + WIDTH'(k), 1'b0, 1'b0);
            model_cand[WIDTH*k +: WIDTH] = 32'h7777_0000 + WIDTH'(k);
        end
        Clear    = 1'b1;
        In_Valid = 1'b1;
        In_Data  = 32'hCCCC_CCCC;
        tick();
        Clear    = 1'b0;
        In_Valid = 1'b0;
        checkOutput("clear in_ready", CW'(In_Ready), CW'(1'b1));
        checkOutput("clear bank_valid", CW'(Bank_Valid), CW'(1'b0));
        checkOutput("clear cand_kept", CW'(Cand_Flat), CW'(model_cand));
        v = '{"after_clear", 32'h0000_FFFF, 32'hFFFF_0000, 2, 1'b0, 1'b0, 1'b0, 4'd2};
        applyStimulus(v);
        runResult(v, 1'b1);

        // Asynchronous reset in the middle of SETTLE
        $display("[TB] reset mid-settle");
        v = '{"reset_settle", 32'h0F0F_0F0F, 32'hF0F0_F0F0, 3, 1'b0, 1'b0, 1'b0, 4'd3};
        applyStimulus(v);
        #2;
        Reset = 1'b1;
        #1;
        checkOutput("async cand_flat", CW'(Cand_Flat), CW'(0));
        checkOutput("async target", CW'(Target_Num), CW'(0));
        checkOutput("async bank_valid", CW'(Bank_Valid), CW'(1'b0));
        checkOutput("async result_valid", CW'(Result_Valid), CW'(1'b0));
        checkOutput("async result_index", CW'(Result_Index), CW'(0));
        model_cand   = '0;
        model_target = '0;
        @(negedge Clock);
        Reset = 1'b0;
        tick();
        checkOutput("release in_ready", CW'(In_Ready), CW'(1'b1));
        tick();
        tick();
        checkOutput("release result_valid", CW'(Result_Valid), CW'(1'b0));

        // All candidates equal the target, with a stray ack during LOAD
        $display("[TB] all equal");
        v = '{"all_equal", 32'h3C3C_0F0F, 32'h3C3C_0F0F, 7, 1'b0, 1'b0, 1'b1, 4'd0};
        applyStimulus(v);
        runResult(v, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/corr_candidate_loader.md
Name: corr_candidate_loader

Overview:
- Upstream feeder for the 16-way best-match correlator.
- Accepts a serial stream of 32-bit words over a valid/ready handshake: 16 candidates in order, then 1 target.
- Presents the full bank to the correlator as registered, stable buses.
- Waits a fixed settle time for the correlator's registered index, captures that index and holds it for the downstream consumer until acknowledged.

Parameters:
- WIDTH, 32, bits per candidate and target word
- NUM_CAND, 16, number of candidate slots (index width = 4)
- SETTLE, 2, cycles between target acceptance and index capture; must be >=2 (correlator output is registered)

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- Clear  in  1  synchronous abort; returns to load of slot 0
- In_Data  in  WIDTH  stream word
- In_Valid  in  1  In_Data valid
- In_Ready  out  1  loader accepts a word this cycle
- Cand_Flat  out  NUM_CAND*WIDTH  candidate k (0-based) at bits [WIDTH*k +: WIDTH]; drives correlator Num_(k+1)
- Target_Num  out  WIDTH  target word to correlator
- Bank_Valid  out  1  all 16 candidates and target loaded and stable
- Corr_Index  in  4  best-match index returned by correlator
- Result_Index  out  4  captured best-match index
- Result_Valid  out  1  Result_Index valid; held until Result_Ack
- Result_Ack  in  1  consumer has taken the result

Behaviour:
- Reset (asynchronous, active-high): state LOAD, word count 0, Cand_Flat=0, Target_Num=0, Bank_Valid=0, Result_Index=0, Result_Valid=0, settle counter 0. In_Ready=1 after reset release.
- States:
  - LOAD: In_Ready=1. Word accepted on an edge where In_Valid&&In_Ready.
    - Count 0..15: write slot[count].
    - Count 16: write Target_Num, go to SETTLE with settle counter cleared.
    - Count increments per accepted word only; In_Valid gaps stall with no side effects.
  - SETTLE: In_Ready=0, Bank_Valid=1. Counter increments each cycle. On the SETTLE-th edge after target acceptance: Result_Index<=Corr_Index, Result_Valid<=1, go to HOLD.
  - HOLD: In_Ready=0, Bank_Valid=1, Result_Valid=1, Result_Index stable. Result_Ack=1 on an edge: go to LOAD, count 0, Bank_Valid<=0, Result_Valid<=0.
- Result_Index retains its value after Ack until the next capture.
- Bank registers keep their old contents during reload and are overwritten slot by slot. The correlator sees a partial bank during LOAD; consumers qualify only on Result_Valid.
- Timing: target handshake at edge E0 -> Result_Valid high after edge E0+SETTLE. For SETTLE=2 this is 2 cycles. Minimum full turnaround is 17 load cycles + SETTLE + 1 ack cycle.
- Clear: highest synchronous priority, over In_Valid and Result_Ack, in any state.
  - Next state LOAD, count 0, Bank_Valid=0, Result_Valid=0.
  - Cand_Flat, Target_Num and Result_Index are not cleared.
  - A word presented in the same cycle as Clear is not accepted.
- Result_Ack outside HOLD is ignored. In_Valid outside LOAD is ignored (In_Ready=0, no write).
- Reset mid-operation (any state) yields reset values immediately; a partial load is discarded.
- Count is 5 bits and never exceeds 16; no wrap.
- Capture is a plain register copy of Corr_Index. Tie-breaking is defined by the correlator (lowest index wins).

Decomposition:
- Shared package: WIDTH, NUM_CAND, index width (4), count width (5), state encoding (LOAD, SETTLE, HOLD). The correlator uses the same package for WIDTH and NUM_CAND.
- No sub-module. Single FSM with word counter and settle counter. Slot write uses a decoded enable from count.

Test Plan:
- Load slots 0..15 = 32'h0000_0000 except slot 4 = 32'hA5A5_A5A5, target = 32'hA5A5_A5A5, correlator instantiated -> Result_Valid rises 2 cycles after target handshake, Result_Index=4, Bank_Valid=1.
- Same load with In_Valid deasserted every other cycle -> exactly 17 words accepted, Cand_Flat slot order correct, Result_Index=4; In_Ready=0 in SETTLE/HOLD; extra words presented there are not written.
- Hold Result_Ack=0 for 10 cycles -> Result_Valid and Result_Index=4 stable. Pulse Ack -> next cycle Result_Valid=0, Bank_Valid=0, In_Ready=1. Reload with slot 15 = target, all other slots = ~target -> Result_Index=15.
- Accept 7 words, assert Clear together with In_Valid -> that word is not accepted, count returns 0. Next 17 words load from slot 0; the result reflects the new bank only.
- Assert Reset asynchronously mid-SETTLE -> all outputs at reset values without a clock edge. After release, In_Ready=1 and Result_Valid stays 0 until a full new load completes.
- All candidates equal the target -> Result_Index=0 (correlator tie rule); Result_Ack asserted during LOAD has no effect.
